psum_collector: RTL and testbench

Drain-side reader for the CIM macro partial-sum handshake. Monitors the per-sub-macro `psum_data_ready` flags, grants one sub-macro at a time in round-robin order, and snapshots its full column psum vector into a local buffer. It acknowledges the sub-macro one cycle later and streams the vector out as fixed-width beats over a valid/ready interface toward the accumulation/output buffer. Sits directly after the CIM macro and is the single consumer of its `psum_buff_out`/`psum_data_ready`/`psum_ack` bus.

---
 rtl/psum_collector.sv | 122 ++++++++++++
 tb/tb_psum_collector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// Drain-side reader for the CIM macro psum handshake: round-robin grants one
// ready sub-macro, snapshots its column vector and streams it out as beats.
module psum_collector #(
    parameter  int NUM_SUB_MACROS = 4,
    parameter  int NUM_COLS       = 32,
    parameter  int ODATA_WIDTH    = 21,
    parameter  int COLS_PER_BEAT  = 4,
    localparam int NUM_BEATS      = NUM_COLS / COLS_PER_BEAT,
    localparam int ID_W           = $clog2(NUM_SUB_MACROS),
    localparam int BEAT_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_SUB_MACROS-1:0]                     psum_data_ready,
    input  logic [NUM_SUB_MACROS*NUM_COLS*ODATA_WIDTH-1:0] psum_buff_out,
    output logic [NUM_SUB_MACROS-1:0]                     psum_ack,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [COLS_PER_BEAT*ODATA_WIDTH-1:0]          out_data,
    output logic [ID_W-1:0]                               out_macro_id,
    output logic [BEAT_W-1:0]                             out_beat_idx,
    output logic                                          out_last,
    output logic                                          busy
);
    localparam int VEC_W   = NUM_COLS * ODATA_WIDTH;
    localparam int BEAT_DW = COLS_PER_BEAT * ODATA_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    // The snapshot is stored beat-major so a beat is a plain array select.
    logic [NUM_SUB_MACROS-1:0][VEC_W-1:0]  in_vec;
    logic [NUM_BEATS-1:0][BEAT_DW-1:0]     vec_q, vec_d;
    state_t                                state_q, state_d;
    logic [ID_W-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]                       grant_q, grant_d;
    logic [BEAT_W-1:0]                     beat_cnt_q, beat_cnt_d;
    logic                                  valid_q, valid_d;
    logic [NUM_SUB_MACROS-1:0]             ack_q, ack_d;

    logic            found;
    logic [ID_W-1:0] pick, idx;

    assign in_vec = psum_buff_out;

    // First ready bit at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SUB_MACROS; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_SUB_MACROS);
            if (!found && psum_data_ready[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        valid_d    = valid_q;
        vec_d      = vec_q;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = STREAM;
                    grant_d    = pick;
                    vec_d      = in_vec[pick];
                    ack_d      = NUM_SUB_MACROS'(1) << pick;
                    rr_ptr_d   = ID_W'((int'(pick) + 1) % NUM_SUB_MACROS);
                    beat_cnt_d = '0;
                    valid_d    = 1'b1;
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            ack_q      <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            vec_q      <= vec_d;
        end
    end

    assign psum_ack     = ack_q;
    assign out_valid    = valid_q;
    assign out_data     = vec_q[beat_cnt_q];
    assign out_macro_id = grant_q;
    assign out_beat_idx = beat_cnt_q;
    assign out_last     = valid_q && (beat_cnt_q == LAST_BEAT);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: default build plus a single-beat build
// (COLS_PER_BEAT=32) sharing clock, reset and psum vectors.
module tb_psum_collector;
    localparam int NSM = 4;
    localparam int NC  = 32;
    localparam int W   = 21;
    localparam int NB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NSM*NC*W-1:0] buff;

    logic [NSM-1:0] rdy0 = '0;
    logic [NSM-1:0] psum_ack;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [4*W-1:0] out_data;
    logic [1:0]     out_macro_id;
    logic [2:0]     out_beat_idx;
    logic           out_last, busy;

    logic [NSM-1:0] rdy1 = '0;
    logic [NSM-1:0] psum_ack1;
    logic           out_valid1;
    logic           out_ready1 = 1'b1;
    logic [NC*W-1:0] out_data1;
    logic [1:0]     out_macro_id1;
    logic [0:0]     out_beat_idx1;
    logic           out_last1, busy1;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit stall_mode = 0;
    bit reraise = 0;
    int rr_cnt[NSM];
    int grants[$];
    int ack_cyc[$];
    int grants1[$];

    psum_collector u_dut (
        .clk(clk), .rst(rst), .psum_data_ready(rdy0), .psum_buff_out(buff),
        .psum_ack(psum_ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_macro_id(out_macro_id),
        .out_beat_idx(out_beat_idx), .out_last(out_last), .busy(busy)
    );

    psum_collector #(.COLS_PER_BEAT(32)) u_dut1 (
        .clk(clk), .rst(rst), .psum_data_ready(rdy1), .psum_buff_out(buff),
        .psum_ack(psum_ack1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_macro_id(out_macro_id1),
        .out_beat_idx(out_beat_idx1), .out_last(out_last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Sub-macro 2 carries c+100; the others differ in the upper bits.
    function automatic logic [W-1:0] pv(input int i, input int c);
        return W'(((i ^ 2) << 17) | (c + 100));
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, and model the senders:
    // an acked sub-macro drops ready, optionally re-raising it later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NSM; i++)
            if (rr_cnt[i] > 0) begin
                rr_cnt[i]--;
                if (rr_cnt[i] == 0) rdy0[i] = 1'b1;
            end
        if (psum_ack != '0) begin
            chk("ack_1hot", 128'($onehot(psum_ack)), 128'(1));
            for (int i = 0; i < NSM; i++)
                if (psum_ack[i]) begin
                    grants.push_back(i);
                    ack_cyc.push_back(cyc);
                    rdy0[i] = 1'b0;
                    if (reraise) rr_cnt[i] = 3;
                end
        end
        for (int i = 0; i < NSM; i++)
            if (psum_ack1[i]) begin
                grants1.push_back(i);
                rdy1[i] = 1'b0;
            end
    endtask

    // Receive one vector from u_dut, checking every beat (and re-checking it
    // on stall cycles). Returns early, without ticking, when beat abort_at shows.
    task automatic recv_vec(input int id, input int abort_at, output int last_cyc);
        int k = 0;
        int p = 0;
        int waitn = 0;
        bit first = 1;
        bit r;
        last_cyc = -1;
        while (!out_valid && waitn < 40) begin
            tick();
            waitn++;
        end
        chk("vld_wait", 128'(out_valid), 128'(1));
        if (!out_valid) return;
        while (k < NB && p < 200) begin
            if (k == abort_at) return;
            chk("vld", 128'(out_valid), 128'(1));
            chk("busy", 128'(busy), 128'(1));
            chk("id", 128'(out_macro_id), 128'(id));
            chk("beat", 128'(out_beat_idx), 128'(k));
            chk("last", 128'(out_last), 128'(k == NB - 1));
            chk("ack", 128'(psum_ack), first ? 128'(1 << id) : 128'(0));
            for (int j = 0; j < 4; j++)
                chk("col", 128'(out_data[j*W +: W]), 128'(pv(id, k*4 + j)));
            first = 0;
            r = stall_mode ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            out_ready = r;
            if (r && k == NB - 1) last_cyc = cyc;
            tick();
            if (r) k++;
        end
        chk("vec_done", 128'(k), 128'(NB));
        out_ready = 1'b1;
    endtask

    initial begin
        int lc, lc1, s, n0;
        int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NSM; i++) begin
            rr_cnt[i] = 0;
            for (int c = 0; c < NC; c++) buff[(i*NC + c)*W +: W] = pv(i, c);
        end

        // Reset values
        tick(); tick();
        chk("rst_ack", 128'(psum_ack), 128'(0));
        chk("rst_vld", 128'(out_valid), 128'(0));
        chk("rst_last", 128'(out_last), 128'(0));
        chk("rst_beat", 128'(out_beat_idx), 128'(0));
        chk("rst_id", 128'(out_macro_id), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        rst = 1'b0;
        tick();

        // 1: single vector from sub-macro 2
        s = grants.size();
        rdy0 = 4'b0100;
        recv_vec(2, NB, lc);
        chk("t1_busy", 128'(busy), 128'(0));
        chk("t1_vld", 128'(out_valid), 128'(0));
        tick(); tick();
        chk("t1_nack", 128'(grants.size() - s), 128'(1));

        // 2: all ready at reset, rotating grants with 9-cycle period
        rst = 1'b1;
        rdy0 = 4'b1111;
        reraise = 1;
        tick(); tick();
        rst = 1'b0;
        s = grants.size();
        for (int v = 0; v < 6; v++) recv_vec(exp_ord[v], NB, lc);
        reraise = 0;
        for (int i = 0; i < NSM; i++) rr_cnt[i] = 0;
        rdy0 = '0;
        chk("t2_ngrant", 128'(grants.size() - s), 128'(6));
        for (int v = 0; v < 6 && s + v < grants.size(); v++) begin
            chk("t2_order", 128'(grants[s+v]), 128'(exp_ord[v]));
            if (v > 0) chk("t2_period", 128'(ack_cyc[s+v] - ack_cyc[s+v-1]), 128'(9));
        end
        tick();

        // 3: backpressure 1,0,0,1 on sub-macro 3 (rr_ptr is 2)
        s = grants.size();
        stall_mode = 1;
        rdy0 = 4'b1000;
        recv_vec(3, NB, lc);
        stall_mode = 0;
        tick(); tick();
        chk("t3_nack", 128'(grants.size() - s), 128'(1));

        // 4: sub-macro 0 raises ready while sub-macro 1 streams
        s = grants.size();
        rdy0 = 4'b0010;
        tick();
        chk("t4_ack1", 128'(psum_ack), 128'(4'b0010));
        rdy0[0] = 1'b1;
        recv_vec(1, NB, lc1);
        recv_vec(0, NB, lc);
        tick(); tick();
        chk("t4_ack0_cyc", 128'(ack_cyc[$]), 128'(lc1 + 2));
        n0 = 0;
        for (int g = s; g < grants.size(); g++) if (grants[g] == 0) n0++;
        chk("t4_ack0_once", 128'(n0), 128'(1));

        // 5: reset on beat 3 of sub-macro 3 while sub-macro 0 waits (rr_ptr is 1)
        rdy0 = 4'b1000;
        tick();
        chk("t5_ack3", 128'(psum_ack), 128'(4'b1000));
        rdy0[0] = 1'b1;
        recv_vec(3, 3, lc);
        chk("t5_at_b3", 128'(out_beat_idx), 128'(3));
        rst = 1'b1;
        tick();
        chk("t5_vld", 128'(out_valid), 128'(0));
        chk("t5_ack", 128'(psum_ack), 128'(0));
        chk("t5_last", 128'(out_last), 128'(0));
        chk("t5_beat", 128'(out_beat_idx), 128'(0));
        chk("t5_id", 128'(out_macro_id), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_data", 128'(out_data), 128'(0));
        rst = 1'b0;
        recv_vec(0, NB, lc);
        chk("t5_idle", 128'(busy), 128'(0));

        // 6: single-beat build, all four ready, 2-cycle period
        rdy1 = 4'b1111;
        tick();
        for (int v = 0; v < NSM; v++) begin
            chk("t6_ack", 128'(psum_ack1), 128'(1 << v));
            chk("t6_vld", 128'(out_valid1), 128'(1));
            chk("t6_id", 128'(out_macro_id1), 128'(v));
            chk("t6_beat", 128'(out_beat_idx1), 128'(0));
            chk("t6_last", 128'(out_last1), 128'(1));
            chk("t6_c0", 128'(out_data1[0 +: W]), 128'(pv(v, 0)));
            chk("t6_c17", 128'(out_data1[17*W +: W]), 128'(pv(v, 17)));
            chk("t6_c31", 128'(out_data1[31*W +: W]), 128'(pv(v, 31)));
            tick();
            chk("t6_bubble", 128'(out_valid1), 128'(0));
            tick();
        end
        chk("t6_ngrant", 128'(grants1.size()), 128'(4));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
